demuxpipe: RTL and testbench



---
 rtl/demuxpipe.sv | 109 ++++++++++
 tb/tb_demuxpipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demuxpipe.sv
// Pipelined 1-to-N valid/ready demultiplexer: every beat carries a destination tag and
// leaves on exactly one output; beats whose tag names no output are discarded and flagged on drop.
module demuxpipe #(
    parameter int DWIDTH   = 16,
    parameter int OUTPUTS  = 4,
    parameter int PIPELINE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DWIDTH-1:0]            s_data,
    input  logic [$clog2(OUTPUTS)-1:0]   s_sel,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DWIDTH*OUTPUTS-1:0]    m_data,
    output logic [OUTPUTS-1:0]           m_valid,
    input  logic [OUTPUTS-1:0]           m_ready,
    output logic                         drop
);
    localparam int SW   = $clog2(OUTPUTS);
    localparam bit POW2 = (OUTPUTS == (1 << SW));

    // With a power-of-two output count every tag value is a real destination.
    function automatic logic in_range(input logic [SW-1:0] tag);
        if (POW2) return 1'b1;
        return {1'b0, tag} < (SW + 1)'(OUTPUTS);
    endfunction

    generate
        if (PIPELINE == 0) begin : g_comb
            logic w_sel_ok;
            logic w_unused;

            assign w_sel_ok = in_range(s_sel);
            assign w_unused = &{1'b0, clk, rst_n};
            assign s_ready  = w_sel_ok ? m_ready[s_sel] : 1'b1;
            assign m_data   = {OUTPUTS{s_data}};
            assign drop     = POW2 ? 1'b0 : (s_valid && !w_sel_ok);

            for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_valid
                assign m_valid[gi] = s_valid && (s_sel == SW'(gi));
            end
        end else begin : g_pipe
            localparam int LAST = PIPELINE - 1;

            logic [PIPELINE-1:0] r_v;
            logic [DWIDTH-1:0]   r_d [PIPELINE];
            logic [SW-1:0]       r_t [PIPELINE];
            logic [PIPELINE-1:0] w_rdy;
            logic                w_last_ok;
            logic                w_out_rdy;

            // An out-of-range beat at the head is always consumed (discarded).
            assign w_last_ok   = in_range(r_t[LAST]);
            assign w_out_rdy   = w_last_ok ? m_ready[r_t[LAST]] : 1'b1;
            assign w_rdy[LAST] = !r_v[LAST] || w_out_rdy;

            for (genvar gi = 0; gi < LAST; gi++) begin : g_rdy
                assign w_rdy[gi] = !r_v[gi] || w_rdy[gi+1];
            end

            assign s_ready = w_rdy[0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= '0;
                end else begin
                    if (w_rdy[0]) r_v[0] <= s_valid;
                    for (int k = 1; k < PIPELINE; k++) begin
                        if (w_rdy[k]) r_v[k] <= r_v[k-1];
                    end
                end
            end

            // Payload is qualified by r_v, so it carries no reset.
            always_ff @(posedge clk) begin
                if (w_rdy[0]) begin
                    r_d[0] <= s_data;
                    r_t[0] <= s_sel;
                end
                for (int k = 1; k < PIPELINE; k++) begin
                    if (w_rdy[k]) begin
                        r_d[k] <= r_d[k-1];
                        r_t[k] <= r_t[k-1];
                    end
                end
            end

            assign m_data = {OUTPUTS{r_d[LAST]}};

            for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_valid
                assign m_valid[gi] = r_v[LAST] && (r_t[LAST] == SW'(gi));
            end

            if (POW2) begin : g_nodrop
                assign drop = 1'b0;
            end else begin : g_drop
                logic r_drop;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_drop <= 1'b0;
                    else        r_drop <= r_v[LAST] && !w_last_ok;
                end

                assign drop = r_drop;
            end
        end
    endgenerate

endmodule

// File: tb/tb_demuxpipe.sv
// Scoreboard bench for demuxpipe: four instances with different depth/output counts,
// directed stimulus pushes expected beats, a free-running monitor pops on every output event.
module tb_demuxpipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] sd   [4];
    logic [1:0]  ss   [4];
    logic        sv   [4];
    logic        srdy [4];
    logic [3:0]  mrdy [4];
    logic [3:0]  mval [4];
    logic [63:0] mdat [4];
    logic        drp  [4];

    // cfg 0: P=2 O=4, cfg 1: P=1 O=3, cfg 2: P=0 O=4, cfg 3: P=3 O=4
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
            localparam int P = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 0 : 3;
            localparam int O = (gi == 1) ? 3 : 4;
            logic [O-1:0]    w_mv;
            logic [O*16-1:0] w_md;

            demuxpipe #(.DWIDTH(16), .OUTPUTS(O), .PIPELINE(P)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .s_data(sd[gi]), .s_sel(ss[gi]), .s_valid(sv[gi]), .s_ready(srdy[gi]),
                .m_data(w_md), .m_valid(w_mv), .m_ready(mrdy[gi][O-1:0]), .drop(drp[gi])
            );

            assign mval[gi] = 4'(w_mv);
            assign mdat[gi] = 64'(w_md);
        end
    endgenerate

    function automatic int pdepth(int g);
        case (g)
            0: return 2;
            1: return 1;
            2: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int odeg(int g);
        return (g == 1) ? 3 : 4;
    endfunction

    typedef struct {
        int          g;
        int          idx;   // destination output, 15 = discarded
        logic [15:0] d;
        int          cyc;   // required output cycle, -1 = not timed
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          w;
    logic [3:0]  prev_stall [4];
    logic [3:0]  prev_val   [4];
    logic [63:0] prev_dat   [4];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(int g, int sel, logic [15:0] d, bit timed);
        exp_t e;
        e.g   = g;
        e.idx = (sel < odeg(g)) ? sel : 15;
        e.d   = d;
        e.cyc = timed ? cyc + pdepth(g) + ((sel >= odeg(g) && pdepth(g) > 0) ? 1 : 0) : -1;
        exp_q.push_back(e);
    endtask

    task automatic pop_event(int g, int idx, logic [15:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: cfg %0d out %0d data %h, required no beat", g, idx, d);
            return;
        end
        e = exp_q.pop_front();
        $display("[TB] cfg %0d out %0d data %h cycle %0d", g, idx, d, cyc);
        check("beat_cfg", 64'(g), 64'(e.g));
        check("beat_dest", 64'(idx), 64'(e.idx));
        if (idx != 15) check("beat_data", 64'(d), 64'(e.d));
        if (e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                for (int g = 0; g < 4; g++) prev_stall[g] = 4'b0;
                continue;
            end
            for (int g = 0; g < 4; g++) begin
                if (drp[g]) pop_event(g, 15, 16'h0);
                for (int i = 0; i < 4; i++) begin
                    if (mval[g][i] && mrdy[g][i]) pop_event(g, i, mdat[g][i*16 +: 16]);
                end
                if (mval[g] != 4'b0) check("onehot", 64'($countones(mval[g]) <= 1), 64'(1));
                if (prev_stall[g] != 4'b0) begin
                    check("hold_valid", 64'(mval[g]), 64'(prev_val[g]));
                    check("hold_data", mdat[g], prev_dat[g]);
                end
                prev_stall[g] = (pdepth(g) > 0) ? (mval[g] & ~mrdy[g]) : 4'b0;
                prev_val[g]   = mval[g];
                prev_dat[g]   = mdat[g];
            end
        end
    endtask

    task automatic send(int g, int sel, logic [15:0] d, bit timed, output int waited);
        int n;
        sv[g] = 1'b1;
        ss[g] = 2'(sel);
        sd[g] = d;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (srdy[g]) break;
        end
        waited = n;
        if (n == 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: cfg %0d s_ready low for %0d cycles, required high", g, n);
        end else begin
            push_exp(g, sel, d, timed);
        end
        @(posedge clk);
        #1;
        sv[g] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(int g, int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            sv[g]   = ($urandom % 4) != 0;
            ss[g]   = 2'($urandom % 4);
            sd[g]   = 16'($urandom);
            mrdy[g] = 4'($urandom);
            @(negedge clk);
            if (sv[g] && srdy[g]) push_exp(g, int'(ss[g]), sd[g], 1'b0);
            @(posedge clk);
            #1;
        end
        sv[g]   = 1'b0;
        mrdy[g] = 4'hF;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            sd[g] = 16'h0; ss[g] = 2'd0; sv[g] = 1'b0; mrdy[g] = 4'hF;
            prev_stall[g] = 4'b0; prev_val[g] = 4'b0; prev_dat[g] = 64'h0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check("reset_mvalid", 64'(mval[g]), 64'(0));
            check("reset_sready", 64'(srdy[g]), 64'(1));
            check("reset_drop", 64'(drp[g]), 64'(0));
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate stream through the two-stage pipe.
        for (int n = 0; n < 8; n++) begin
            send(0, n % 4, 16'h1000 + 16'(n), 1'b1, w);
            check("t1_no_stall", 64'(w), 64'(0));
        end
        drain();

        // Stalled destination 1 blocks later beats until released.
        mrdy[0] = 4'b1101;
        send(0, 1, 16'h2001, 1'b0, w);
        send(0, 2, 16'h2002, 1'b0, w);
        fork
            send(0, 3, 16'h2003, 1'b0, w);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t2_stall_ready", 64'(srdy[0]), 64'(0));
                    check("t2_hold_out", 64'(mval[0]), 64'(4'b0010));
                end
                @(posedge clk);
                #1 mrdy[0] = 4'hF;
            end
        join
        drain();

        // Out-of-range tag is discarded with a drop pulse, the next beat follows.
        send(1, 3, 16'hDEAD, 1'b1, w);
        check("t3_drop_ready", 64'(w), 64'(0));
        send(1, 0, 16'hBEEF, 1'b1, w);
        check("t3_next_ready", 64'(w), 64'(0));
        drain();

        // Combinational pass-through.
        @(posedge clk);
        #1;
        ss[2] = 2'd2; sv[2] = 1'b1; mrdy[2] = 4'hF;
        #1 check("t4_mvalid_sel2", 64'(mval[2]), 64'(4'b0100));
        check("t4_sready_sel2", 64'(srdy[2]), 64'(1));
        mrdy[2] = 4'b1011;
        #1 check("t4_sready_blocked", 64'(srdy[2]), 64'(0));
        ss[2] = 2'd0;
        #1 check("t4_mvalid_sel0", 64'(mval[2]), 64'(4'b0001));
        check("t4_sready_sel0", 64'(srdy[2]), 64'(1));
        sv[2] = 1'b0; mrdy[2] = 4'hF;
        #1 check("t4_mvalid_idle", 64'(mval[2]), 64'(0));
        @(posedge clk);
        #1;
        send(2, 1, 16'h4001, 1'b1, w);
        send(2, 3, 16'h4003, 1'b1, w);
        drain();

        // Three-stage latency, then asynchronous reset with beats in flight.
        send(3, 2, 16'h5002, 1'b1, w);
        drain();
        mrdy[3] = 4'h0;
        send(3, 1, 16'h5101, 1'b0, w);
        send(3, 2, 16'h5102, 1'b0, w);
        repeat (2) @(posedge clk);
        #1 check("t5_head_visible", 64'(mval[3]), 64'(4'b0010));
        rst_n = 1'b0;
        #1 check("t5_async_mvalid", 64'(mval[3]), 64'(0));
        check("t5_async_sready", 64'(srdy[3]), 64'(1));
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        mrdy[3] = 4'hF;
        repeat (10) @(posedge clk);
        #1;
        send(3, 3, 16'h5203, 1'b1, w);
        drain();

        // Random traffic against the in-order scoreboard.
        rand_run(0, 4000);
        rand_run(1, 4000);
        rand_run(2, 2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
